// File: rtl/rep_seq_pkg.sv
// Shared types and constants for the REP string-instruction sequencer.
// State encoding, operand-size codes and per-size address step.
package rep_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OPS_B = 2'd0,
    OPS_W = 2'd1,
    OPS_D = 2'd2,
    OPS_Q = 2'd3
  } opsize_t;

  localparam logic [3:0] STEP_B = 4'd1;
  localparam logic [3:0] STEP_W = 4'd2;
  localparam logic [3:0] STEP_D = 4'd4;
  localparam logic [3:0] STEP_Q = 4'd8;

  function automatic logic [3:0] step_of(input logic [1:0] op);
    logic [3:0] s;
    s = STEP_B;
    unique case (opsize_t'(op))
      OPS_B: s = STEP_B;
      OPS_W: s = STEP_W;
      OPS_D: s = STEP_D;
      OPS_Q: s = STEP_Q;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rep_addr_step.sv
// Advances one string address by the operand size, up or down under df.
// Kogge-Stone prefix adder; subtraction is add of ~step with carry-in 1.
module rep_addr_step
  import rep_seq_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [1:0]    opsize,
  input  logic          df,
  output logic [AW-1:0] next
);

  logic [AW-1:0] step;
  logic [AW-1:0] b;
  logic [AW-1:0] p;
  logic [AW-1:0] g;
  logic [AW-1:0] pp;
  logic [AW-1:0] gn;
  logic [AW-1:0] pn;
  logic [AW-1:0] c;

  assign step = AW'(step_of(opsize));
  assign b    = df ? ~step : step;

  always_comb begin
    p    = addr ^ b;
    g    = addr & b;
    g[0] = g[0] | (p[0] & df);
    pp   = p;
    gn   = g;
    pn   = pp;
    for (int k = 1; k < AW; k = k * 2) begin
      gn = g;
      pn = pp;
      for (int i = k; i < AW; i++) begin
        gn[i] = g[i] | (pp[i] & g[i-k]);
        pn[i] = pp[i] & pp[i-k];
      end
      g  = gn;
      pp = pn;
    end
    c    = {g[AW-2:0], df};
    next = p ^ c;
  end

endmodule

// File: rtl/rep_sequencer.sv
// Expands REP string instructions into one memory micro-op per iteration.
// Optional REPE/REPNE early exit under macro REP_SEQ_ZF_TERM_EN.
module rep_sequencer
  import rep_seq_pkg::*;
#(
  parameter int AW = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          valid_in,
  input  logic          rep_in,
  input  logic [CW-1:0] rep_num,
  input  logic [1:0]    opsize_in,
  input  logic          df_in,
  input  logic [AW-1:0] mem_addr1_in,
  input  logic [AW-1:0] mem_addr2_in,
  input  logic          ds_stall,
  input  logic          flush,
`ifdef REP_SEQ_ZF_TERM_EN
  input  logic          zf_term,
  input  logic          rep_mode,
`endif
  output logic          valid_out,
  output logic          stall_up,
  output logic [AW-1:0] addr1_out,
  output logic [AW-1:0] addr2_out,
  output logic [1:0]    opsize_out,
  output logic [CW-1:0] remaining,
  output logic          first_iter,
  output logic          last_iter,
  output logic          null_rep
);

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [AW-1:0] a1, a1_n;
  logic [AW-1:0] a2, a2_n;
  logic [1:0]    op, op_n;
  logic          df, df_n;

  logic          valid_n;
  logic [AW-1:0] addr1_n;
  logic [AW-1:0] addr2_n;
  logic [1:0]    opsize_n;
  logic [CW-1:0] rem_n;
  logic          first_n;
  logic          last_n;
  logic          null_n;

  logic          in_run;
  logic [AW-1:0] base1;
  logic [AW-1:0] base2;
  logic [1:0]    sop;
  logic          sdf;
  logic [AW-1:0] step1;
  logic [AW-1:0] step2;
  logic          kill;

  assign in_run   = (state == RUN);
  assign stall_up = in_run | ds_stall;

  // Steppers are shared: inputs on acceptance, latched values in RUN.
  assign base1 = in_run ? a1 : mem_addr1_in;
  assign base2 = in_run ? a2 : mem_addr2_in;
  assign sop   = in_run ? op : opsize_in;
  assign sdf   = in_run ? df : df_in;

  rep_addr_step #(.AW(AW)) u_step1 (
    .addr   (base1),
    .opsize (sop),
    .df     (sdf),
    .next   (step1)
  );

  rep_addr_step #(.AW(AW)) u_step2 (
    .addr   (base2),
    .opsize (sop),
    .df     (sdf),
    .next   (step2)
  );

`ifdef REP_SEQ_ZF_TERM_EN
  assign kill = (~rep_mode & ~zf_term) | (rep_mode & zf_term);
`else
  assign kill = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    count_n  = count;
    a1_n     = a1;
    a2_n     = a2;
    op_n     = op;
    df_n     = df;
    valid_n  = valid_out;
    addr1_n  = addr1_out;
    addr2_n  = addr2_out;
    opsize_n = opsize_out;
    rem_n    = remaining;
    first_n  = first_iter;
    last_n   = last_iter;
    null_n   = null_rep;
    if (flush) begin
      state_n = IDLE;
      count_n = '0;
      valid_n = 1'b0;
    end else if (!ds_stall) begin
      unique case (state)
        IDLE: begin
          valid_n = valid_in;
          first_n = valid_in;
          last_n  = valid_in;
          null_n  = 1'b0;
          rem_n   = '0;
          if (valid_in) begin
            addr1_n  = mem_addr1_in;
            addr2_n  = mem_addr2_in;
            opsize_n = opsize_in;
            null_n   = rep_in && (rep_num == '0);
            if (rep_in && (rep_num > CW'(1))) begin
              last_n  = 1'b0;
              rem_n   = rep_num - CW'(1);
              count_n = rep_num - CW'(1);
              a1_n    = step1;
              a2_n    = step2;
              op_n    = opsize_in;
              df_n    = df_in;
              state_n = RUN;
            end
          end
        end
        RUN: begin
          if (kill) begin
            valid_n = 1'b0;
            first_n = 1'b0;
            last_n  = 1'b0;
            null_n  = 1'b0;
            rem_n   = '0;
            count_n = '0;
            state_n = IDLE;
          end else begin
            valid_n  = 1'b1;
            addr1_n  = a1;
            addr2_n  = a2;
            opsize_n = op;
            first_n  = 1'b0;
            null_n   = 1'b0;
            rem_n    = count - CW'(1);
            last_n   = (count == CW'(1));
            count_n  = count - CW'(1);
            a1_n     = step1;
            a2_n     = step2;
            if (count == CW'(1)) state_n = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      count      <= '0;
      a1         <= '0;
      a2         <= '0;
      op         <= '0;
      df         <= 1'b0;
      valid_out  <= 1'b0;
      addr1_out  <= '0;
      addr2_out  <= '0;
      opsize_out <= '0;
      remaining  <= '0;
      first_iter <= 1'b0;
      last_iter  <= 1'b0;
      null_rep   <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      a1         <= a1_n;
      a2         <= a2_n;
      op         <= op_n;
      df         <= df_n;
      valid_out  <= valid_n;
      addr1_out  <= addr1_n;
      addr2_out  <= addr2_n;
      opsize_out <= opsize_n;
      remaining  <= rem_n;
      first_iter <= first_n;
      last_iter  <= last_n;
      null_rep   <= null_n;
    end
  end

endmodule

// File: doc/rep_sequencer.md
Name: rep_sequencer

Overview:
- Sits directly downstream of the register-read/address-generation stage and consumes its rep_num, mem_addr1/mem_addr2 and opsize outputs.
- Expands a REP-prefixed string instruction into one micro-op per iteration toward the memory stage.
- Each iteration advances both addresses by the operand size and decrements the count.
- Non-REP instructions pass through with one cycle of latency.

Parameters:
AW, 32, address width of mem_addr1/mem_addr2 and outputs
CW, 32, iteration count width (rep_num)

Ports:
clk  in  1  clock
clr  in  1  asynchronous active-high reset
valid_in  in  1  upstream instruction valid
rep_in  in  1  instruction carries a REP prefix
rep_num  in  CW  iteration count (ECX); 0 when rep_in=0
opsize_in  in  2  0=1B, 1=2B, 2=4B, 3=8B
df_in  in  1  direction flag; 1 = addresses decrement
mem_addr1_in  in  AW  source/first memory address
mem_addr2_in  in  AW  destination/second memory address
ds_stall  in  1  downstream latch cannot accept this cycle
flush  in  1  synchronous pipeline flush (branch mispredict / exception)
valid_out  out  1  micro-op valid toward memory stage
stall_up  out  1  hold upstream latch
addr1_out  out  AW  iteration address 1
addr2_out  out  AW  iteration address 2
opsize_out  out  2  registered opsize
remaining  out  CW  count remaining after this micro-op
first_iter  out  1  first micro-op of the instruction
last_iter  out  1  final micro-op of the instruction
null_rep  out  1  REP with count 0: architectural no-op, no memory access

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE; all outputs and registers are 0.
- States: IDLE, RUN.
- stall_up = (state==RUN) | ds_stall. This is combinational from state and ds_stall.
- Outputs are registered and update only when ds_stall=0. While ds_stall=1, all output registers hold.
- IDLE, valid_in=1, ds_stall=0:
  - rep_in=0: emit one micro-op next cycle with the input addresses; first_iter=last_iter=1; remaining=0.
  - rep_in=1, rep_num=0: emit valid_out=1, null_rep=1, first_iter=last_iter=1; state stays IDLE.
  - rep_in=1, rep_num=1: same as a single pass-through, with remaining=0.
  - rep_in=1, rep_num>=2: emit iteration 1 (input addresses, first_iter=1, remaining=rep_num-1). Latch the stepped addresses, count=rep_num-1 and opsize, then go to RUN.
- IDLE, valid_in=0: valid_out=0 next cycle (when ds_stall=0).
- RUN, ds_stall=0: emit the latched addresses with remaining=count-1. Then step the addresses and decrement count.
  - When count==1, assert last_iter and return to IDLE.
  - The upstream instruction is held (stall_up=1) until that transition. The next instruction is accepted the cycle after state returns to IDLE.
- Step rule: step = 1<<opsize (1/2/4/8). addr += step when df=0, addr -= step when df=1. Arithmetic is modulo 2^AW; wrap-around is silent.
- opsize and df are captured at acceptance and ignored for the rest of the instruction.
- flush=1 (synchronous, priority over everything except clr): state=IDLE, valid_out=0, count=0. flush takes effect even when ds_stall=1.
- rep_num=2^CW-1 runs the full count with no overflow; count is never compared below 1.

Optional Feature:
Macro REP_SEQ_ZF_TERM_EN. Adds input zf_term (1) and input rep_mode (1; 0=REPE, 1=REPNE).
- With the macro: in RUN, zf_term reports the flag result of the previous CMPS/SCAS iteration.
  - If (rep_mode=0 & zf_term=0) or (rep_mode=1 & zf_term=1), the next emitted micro-op is suppressed. state goes to IDLE, valid_out=0, and the remaining count is discarded.
- Without the macro: the ports are absent; every instruction runs its full count.

Decomposition:
- Shared package rep_seq_pkg:
  - state encoding constants (IDLE=1'b0, RUN=1'b1)
  - opsize codes
  - step-size constants
- One sub-module, rep_addr_step:
  - combinational AW-bit add/subtract of 1<<opsize under df
  - instantiated twice, once per address
  - built on the team's kogeAdder

Test Plan:
1. Non-REP, addr1=0x1000, opsize=2 -> one valid_out, addr1_out=0x1000, first_iter=last_iter=1, stall_up stays 0.
2. REP rep_num=3, opsize=1, df=0, addr1=0x2000, addr2=0x3000 -> addr1_out 0x2000/0x2002/0x2004, addr2_out 0x3000/0x3002/0x3004, remaining 2/1/0, last_iter on the 3rd, stall_up high for 2 cycles.
3. REP rep_num=0 -> single valid_out with null_rep=1; state remains IDLE.
4. REP rep_num=2, df=1, opsize=3, addr1=0x4 -> addr1_out 0x4 then 0xFFFFFFFC (wrap).
5. REP rep_num=4 with ds_stall=1 on iteration 2 for 3 cycles -> outputs hold; no iteration dropped or duplicated; 4 total valid_out.
6. flush during RUN at iteration 2 of 5 -> valid_out=0 next cycle, state IDLE, stall_up=0. clr mid-RUN -> all outputs 0 immediately.
